// File: rtl/fpmul_result_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fpmul_result_buffer
// Description : Registered output stage for the combinational FP32 multiplier.
//               It accepts product words and their U/O/N flags through a
//               valid/ready handshake, cleans each word into a legal IEEE-754
//               single-precision encoding, and queues the results in a small
//               FIFO. It also keeps sticky exception status.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk           in   rising-edge clock
//   reset         in   asynchronous active-high reset
//   in_valid      in   multiplier result valid
//   in_ready      out  buffer can accept (== !full)
//   in_result     in   [31:0] raw multiplier product
//   in_u/o/n      in   underflow / overflow / NaN flags
//   out_valid     out  head entry available (== !empty)
//   out_ready     in   consumer accepts head entry
//   out_data      out  [31:0] cleaned word at the FIFO head (0 when empty)
//   out_flags     out  [2:0] {n,o,u} of the head entry (0 when empty)
//   sticky_flags  out  [2:0] {n,o,u} ORed over accepted entries
//   clear_sticky  in   synchronous clear of sticky_flags
//   count         out  [CW-1:0] current occupancy
// Optional feature macro: FPMUL_FTZ_EN
//   When defined, flag-free denormal words are flushed to signed zero and
//   the entry is tagged with the underflow flag.
// ============================================================================
module fpmul_result_buffer #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_result,
    input  logic          in_u,
    input  logic          in_o,
    input  logic          in_n,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_data,
    output logic [2:0]    out_flags,
    output logic [2:0]    sticky_flags,
    input  logic          clear_sticky,
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    // Storage is deliberately left un-reset; only pointers and count are.
    logic [31:0]   mem_data_q  [DEPTH];
    logic [2:0]    mem_flags_q [DEPTH];

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [2:0]    sticky_q, sticky_d;

    logic          full_w;
    logic          empty_w;
    logic          push_w;
    logic          pop_w;
    logic [31:0]   clean_word_w;
    logic [2:0]    clean_flags_w;

    assign full_w  = (count_q == CW'(DEPTH));
    assign empty_w = (count_q == '0);

    // in_ready depends only on registered state, never on out_ready.
    assign in_ready  = !full_w;
    assign out_valid = !empty_w;

    assign push_w = in_valid && in_ready;
    assign pop_w  = out_valid && out_ready;

    // ------------------------------------------------------------------
    // Word cleaning, priority n > o > u. Stored flags are the raw inputs
    // (plus the FTZ-generated u when that feature is built in).
    // ------------------------------------------------------------------
    always_comb begin
        clean_word_w  = in_result;
        clean_flags_w = {in_n, in_o, in_u};
        if (in_n) begin
            clean_word_w = 32'h7FC0_0000;
        end else if (in_o) begin
            clean_word_w = {in_result[31], 8'hFF, 23'h0};
        end else if (in_u) begin
            clean_word_w = {in_result[31], 31'h0};
        end
`ifdef FPMUL_FTZ_EN
        else if ((in_result[30:23] == 8'h00) && (in_result[22:0] != 23'h0)) begin
            clean_word_w     = {in_result[31], 31'h0};
            clean_flags_w[0] = 1'b1;
        end
`else
        else begin
            clean_word_w = in_result;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Next-state logic for pointers, occupancy and sticky status.
    // ------------------------------------------------------------------
    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        count_d  = count_q;
        sticky_d = clear_sticky ? 3'b000 : sticky_q;

        if (push_w) begin
            wptr_d   = wptr_q + AW'(1);
            // A flag arriving with clear_sticky survives the clear.
            sticky_d = sticky_d | clean_flags_w;
        end
        if (pop_w) begin
            rptr_d = rptr_q + AW'(1);
        end

        case ({push_w, pop_w})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            sticky_q <= 3'b000;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            sticky_q <= sticky_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_w && !reset) begin
            mem_data_q[wptr_q]  <= clean_word_w;
            mem_flags_q[wptr_q] <= clean_flags_w;
        end
    end

    // Head entry comes straight from registered storage, so it is stable
    // while the consumer stalls. Forced to zero when empty.
    assign out_data     = empty_w ? 32'h0  : mem_data_q[rptr_q];
    assign out_flags    = empty_w ? 3'b000 : mem_flags_q[rptr_q];
    assign sticky_flags = sticky_q;
    assign count        = count_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset) begin
            assert (!$isunknown(in_valid))
                else $error("fpmul_result_buffer: in_valid is X/Z");
            assert (!$isunknown(out_ready))
                else $error("fpmul_result_buffer: out_ready is X/Z");
            assert (count_q <= CW'(DEPTH))
                else $error("fpmul_result_buffer: count exceeds DEPTH");
            assert (!(pop_w && empty_w))
                else $error("fpmul_result_buffer: pop while empty");
            assert (!(push_w && full_w))
                else $error("fpmul_result_buffer: push while full");
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fpmul_result_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpmul_result_buffer
// Description : Directed self-checking bench for fpmul_result_buffer
//               (DEPTH = 4). Inputs change 1 ns after each rising edge and
//               outputs are sampled at that same point.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpmul_result_buffer;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_result;
    logic          in_u, in_o, in_n;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_data;
    logic [2:0]    out_flags;
    logic [2:0]    sticky_flags;
    logic          clear_sticky;
    logic [CW-1:0] count;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] sb [$];
    logic [31:0] words [4];

    fpmul_result_buffer #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_u         (in_u),
        .in_o         (in_o),
        .in_n         (in_n),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_flags    (out_flags),
        .sticky_flags (sticky_flags),
        .clear_sticky (clear_sticky),
        .count        (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns past the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] r, input logic [2:0] nou);
        in_valid  = v;
        in_result = r;
        {in_n, in_o, in_u} = nou;
    endtask

    initial begin
        reset        = 1'b1;
        in_valid     = 1'b0;
        in_result    = 32'h0;
        {in_n, in_o, in_u} = 3'b000;
        out_ready    = 1'b0;
        clear_sticky = 1'b0;

        // Reset state, checked asynchronously before any clock edge.
        #3;
        chk("rst_count",     32'(count),        32'd0);
        chk("rst_out_valid", 32'(out_valid),    32'd0);
        chk("rst_in_ready",  32'(in_ready),     32'd1);
        chk("rst_sticky",    32'(sticky_flags), 32'd0);
        chk("rst_out_data",  out_data,          32'h0);
        chk("rst_out_flags", 32'(out_flags),    32'd0);
        step();
        step();
        reset = 1'b0;

        // Single push, latency 1, then pop.
        drive(1'b1, 32'h40C0_0000, 3'b000);
        step();
        drive(1'b0, 32'h0, 3'b000);
        chk("t1_out_valid", 32'(out_valid), 32'd1);
        chk("t1_out_data",  out_data,       32'h40C0_0000);
        chk("t1_out_flags", 32'(out_flags), 32'd0);
        chk("t1_count",     32'(count),     32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t1_count_pop", 32'(count),     32'd0);
        chk("t1_empty",     32'(out_valid), 32'd0);
        chk("t1_data_zero", out_data,       32'h0);

        // Fill to DEPTH with consumer stalled, overflow attempt, drain.
        words[0] = 32'h3F80_0000;
        words[1] = 32'h4000_0000;
        words[2] = 32'h4040_0000;
        words[3] = 32'h4080_0000;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, words[i], 3'b000);
            step();
        end
        chk("t2_in_ready_full", 32'(in_ready), 32'd0);
        chk("t2_count_full",    32'(count),    32'd4);
        drive(1'b1, 32'hDEAD_BEEF, 3'b000);
        step();
        drive(1'b0, 32'h0, 3'b000);
        chk("t2_count_5th",     32'(count),    32'd4);
        chk("t2_head_stall",    out_data,      words[0]);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_pop%0d", i), out_data, words[i]);
            step();
        end
        out_ready = 1'b0;
        chk("t2_count_drained", 32'(count), 32'd0);
        // Refill across the pointer wrap.
        drive(1'b1, 32'h4100_0000, 3'b000);
        step();
        drive(1'b1, 32'h4110_0000, 3'b000);
        step();
        drive(1'b0, 32'h0, 3'b000);
        out_ready = 1'b1;
        chk("t2_wrap0", out_data, 32'h4100_0000);
        step();
        chk("t2_wrap1", out_data, 32'h4110_0000);
        step();
        out_ready = 1'b0;

        // Overflow and NaN cleaning.
        drive(1'b1, 32'hC123_4567, 3'b010);
        step();
        drive(1'b0, 32'h0, 3'b000);
        chk("t3_inf_data",  out_data,       32'hFF80_0000);
        chk("t3_inf_flags", 32'(out_flags), 32'b010);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        drive(1'b1, 32'h1234_5678, 3'b110);
        step();
        drive(1'b0, 32'h0, 3'b000);
        chk("t3_nan_data",  out_data,       32'h7FC0_0000);
        chk("t3_nan_flags", 32'(out_flags), 32'b110);
        chk("t3_sticky",    32'(sticky_flags), 32'b110);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        clear_sticky = 1'b1;
        step();
        clear_sticky = 1'b0;
        chk("t3_sticky_clr", 32'(sticky_flags), 32'b000);

        // Underflow cleaning, then clear coincident with an O push.
        drive(1'b1, 32'h8001_2345, 3'b001);
        step();
        chk("t4_uf_data",   out_data,          32'h8000_0000);
        chk("t4_uf_flags",  32'(out_flags),    32'b001);
        chk("t4_sticky_u",  32'(sticky_flags), 32'b001);
        drive(1'b1, 32'h3F80_0000, 3'b010);
        clear_sticky = 1'b1;
        step();
        drive(1'b0, 32'h0, 3'b000);
        clear_sticky = 1'b0;
        chk("t4_sticky_o",  32'(sticky_flags), 32'b010);
        chk("t4_count",     32'(count),        32'd2);
        out_ready = 1'b1;
        step();
        chk("t4_second",    out_data,          32'h7F80_0000);
        step();
        out_ready = 1'b0;

        // Steady push+pop at count = 2 for 10 cycles.
        sb.delete();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h4200_0000 + 32'(i), 3'b000);
            sb.push_back(32'h4200_0000 + 32'(i));
            step();
        end
        out_ready = 1'b1;
        for (int i = 2; i < 12; i++) begin
            drive(1'b1, 32'h4200_0000 + 32'(i), 3'b000);
            chk($sformatf("t5_head%0d", i), out_data, sb[0]);
            void'(sb.pop_front());
            sb.push_back(32'h4200_0000 + 32'(i));
            step();
            chk($sformatf("t5_count%0d", i), 32'(count), 32'd2);
        end
        chk("t5_head_final", out_data, sb[0]);
        // Asynchronous reset mid-burst, between clock edges.
        #2;
        reset = 1'b1;
        #1;
        chk("t5_rst_count",     32'(count),        32'd0);
        chk("t5_rst_out_valid", 32'(out_valid),    32'd0);
        chk("t5_rst_in_ready",  32'(in_ready),     32'd1);
        drive(1'b0, 32'h0, 3'b000);
        out_ready = 1'b0;
        step();
        reset = 1'b0;
        step();
        chk("t5_post_rst_count", 32'(count), 32'd0);

        // Denormal handling depends on the build option.
        drive(1'b1, 32'h0000_0001, 3'b000);
        step();
        drive(1'b0, 32'h0, 3'b000);
`ifdef FPMUL_FTZ_EN
        chk("t6_denorm_data",   out_data,          32'h0000_0000);
        chk("t6_denorm_flags",  32'(out_flags),    32'b001);
        chk("t6_denorm_sticky", 32'(sticky_flags), 32'b001);
`else
        chk("t6_denorm_data",   out_data,          32'h0000_0001);
        chk("t6_denorm_flags",  32'(out_flags),    32'b000);
        chk("t6_denorm_sticky", 32'(sticky_flags), 32'b000);
`endif
        chk("t6_count", 32'(count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fpmul_result_buffer.md
Name: fpmul_result_buffer

Overview:
- Registered output stage directly downstream of the combinational FP32 multiplier (product).
- Captures the product word and its U/O/N flags with a valid/ready handshake, and cleans each word into an IEEE-754 single-precision encoding.
- Holds cleaned words in a small FIFO and keeps sticky exception status for software or the bench.
- Decouples the multiplier from a stalling consumer.

Parameters:
- DEPTH, 4: FIFO entries; power of two, 2..16.
- CW, $clog2(DEPTH+1): width of the occupancy count.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  multiplier result valid.
- in_ready  output  1  buffer can accept; equals !full.
- in_result  input  32  fp_result from the multiplier.
- in_u  input  1  underflow flag (U).
- in_o  input  1  overflow flag (O).
- in_n  input  1  NaN flag (N).
- out_valid  output  1  head entry available; equals !empty.
- out_ready  input  1  consumer accepts the head entry.
- out_data  output  32  cleaned result at the FIFO head.
- out_flags  output  3  {n,o,u} of the head entry.
- sticky_flags  output  3  {n,o,u} ORed over all accepted entries since reset or clear.
- clear_sticky  input  1  synchronous clear of sticky_flags.
- count  output  CW  current occupancy.

Behaviour:
- Reset is asynchronous and active-high, on clk domain.
  - While reset is high: write/read pointers = 0, count = 0, sticky_flags = 0, out_valid = 0, in_ready = 1.
  - out_data and out_flags = 0 while empty.
  - Storage contents are not reset.
  - Reset mid-operation discards all entries; in-flight handshakes are dropped.
- Push: in_valid && in_ready at a rising edge writes the cleaned word and flags at wptr; wptr increments.
- Pop: out_valid && out_ready at a rising edge increments rptr.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Occupancy:
  - count is +1 on push only, -1 on pop only, unchanged on both or neither.
  - full when count == DEPTH; empty when count == 0.
- Simultaneous push and pop:
  - When full: push is refused because in_ready = 0; pop proceeds. in_ready is not combinationally dependent on out_ready.
  - When empty: push only; no bypass. Data appears on out_data one cycle after push (latency 1).
- out_data and out_flags are driven from the head entry (registered storage); they are stable while out_valid && !out_ready.
- Cleaning, applied on push, priority n > o > u:
  - n = 1: word = 32'h7FC00000 (canonical quiet NaN).
  - o = 1: word = {in_result[31], 8'hFF, 23'h0} (signed infinity).
  - u = 1: word = {in_result[31], 31'h0} (signed zero).
  - Otherwise: word = in_result unchanged.
- Stored flags are the raw {in_n, in_o, in_u}, even when more than one is set.
- Sticky update each cycle: sticky_flags <= (clear_sticky ? 0 : sticky_flags) | (push ? {in_n,in_o,in_u} : 0).
  - A flag arriving in the same cycle as clear_sticky survives the clear.
- in_result and flags are ignored when in_valid = 0.
- X on in_valid or out_ready: simulation assertion fires ($error).
- Assertions:
  - count never exceeds DEPTH.
  - No pop when empty.
  - No push when full.

Optional Feature:
- Macro: FPMUL_FTZ_EN.
- Defined: on push with n = o = u = 0, a word with exponent == 0 and mantissa != 0 (denormal) is replaced by {sign, 31'h0}.
  - The stored u flag and sticky u are set for that entry.
- Undefined: denormal words pass through unchanged and u is taken only from in_u.
- All other behaviour is identical with or without the macro.

Test Plan:
- Reset then one push of in_result = 32'h40C00000, flags 000 -> next cycle out_valid = 1, out_data = 32'h40C00000, out_flags = 3'b000, count = 1; pop -> count = 0.
- Push 4 entries with out_ready = 0 (DEPTH = 4) -> in_ready = 0 and count = 4; a 5th in_valid is not accepted; pops return the 4 words in order, with pointers wrapping on refill.
- Push in_result = 32'hC1234567 with o = 1 -> out_data = 32'hFF800000. Push with n = 1, o = 1 -> out_data = 32'h7FC00000, out_flags = 3'b110.
- Push u = 1 on 32'h80012345 -> out_data = 32'h80000000 and sticky_flags = 3'b001. Pulse clear_sticky in the same cycle as a push with o = 1 -> sticky_flags = 3'b010.
- At count = 2, push and pop in the same cycle for 10 cycles -> count stays 2 and data order is preserved. Assert reset mid-burst -> count = 0 and out_valid = 0 immediately, without waiting for a clock edge.
- With FPMUL_FTZ_EN defined, push 32'h00000001, flags 000 -> out_data = 32'h00000000, out_flags = 3'b001. Without the macro -> out_data = 32'h00000001, out_flags = 3'b000.
